// File: rtl/mem_arb_pkg.sv
// Shared types and bus sizes for the cache-to-RAM line arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } arb_txn_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin winner select; the requester that did not win last time has priority.
module rr_arbiter (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide RAM port between the I-cache (0) and D-cache (1), one
// transaction at a time, with a bounded wait on the RAM side.
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned ADDR_W      = mem_arb_pkg::ADDR_W,
    parameter int unsigned LINE_W      = mem_arb_pkg::LINE_W,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*LINE_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        req_done,
    output logic                    req_err,
    output logic [LINE_W-1:0]       req_rdata,
    output logic                    ram_valid,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [LINE_W-1:0]       ram_wdata,
    input  logic                    ram_ready,
    input  logic                    ram_done,
    input  logic [LINE_W-1:0]       ram_rdata,
    output logic                    timeout_flag
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t        state_q, state_d;
    arb_txn_t          txn_q, txn_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic              err_q, err_d;
    logic              timeout_flag_q, timeout_flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [N_REQ-1:0]  grant;
    logic              timed_out;

    rr_arbiter u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q        <= IDLE;
            txn_q          <= '0;
            id_q           <= 1'b0;
            last_grant_q   <= 1'b1;
            err_q          <= 1'b0;
            timeout_flag_q <= 1'b0;
            cnt_q          <= '0;
            rdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            txn_q          <= txn_d;
            id_q           <= id_d;
            last_grant_q   <= last_grant_d;
            err_q          <= err_d;
            timeout_flag_q <= timeout_flag_d;
            cnt_q          <= cnt_d;
            rdata_q        <= rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        txn_d          = txn_q;
        id_d           = id_q;
        last_grant_d   = last_grant_q;
        err_d          = err_q;
        timeout_flag_d = timeout_flag_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        // >= rather than == so a late ram_ready at the last count still times out in WAIT
        timed_out      = (cnt_q >= CNT_LAST);

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    id_d        = grant[1];
                    txn_d.we    = grant[1] ? req_we[1] : req_we[0];
                    txn_d.addr  = grant[1] ? req_addr[2*ADDR_W-1 -: ADDR_W] : req_addr[ADDR_W-1:0];
                    txn_d.wdata = grant[1] ? req_wdata[2*LINE_W-1 -: LINE_W] : req_wdata[LINE_W-1:0];
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (ram_ready) begin
                    state_d = WAIT;
                end else if (timed_out) begin
                    err_d          = 1'b1;
                    rdata_d        = '0;
                    timeout_flag_d = 1'b1;
                    state_d        = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (ram_done) begin
                    if (!txn_q.we) rdata_d = ram_rdata;
                    state_d = RESP;
                end else if (timed_out) begin
                    err_d          = 1'b1;
                    rdata_d        = '0;
                    timeout_flag_d = 1'b1;
                    state_d        = RESP;
                end
            end
            RESP: begin
                last_grant_d = id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RESET gates req_ready directly so it is 0 while reset is held
    assign req_ready    = (state_q == IDLE && RESET) ? grant : '0;
    assign req_done     = (state_q == RESP) ? (N_REQ'(1) << id_q) : '0;
    assign req_err      = (state_q == RESP) && err_q;
    assign req_rdata    = (state_q == RESP) ? rdata_q : '0;
    assign ram_valid    = (state_q == ISSUE);
    assign ram_we       = txn_q.we;
    assign ram_addr     = txn_q.addr;
    assign ram_wdata    = txn_q.wdata;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a short timeout so the abort path is reachable.
module tb_cache_mem_arbiter;

    localparam logic [127:0] RD1 = 128'hDEAD0123_456789AB_CDEF0011_2233BEEF;
    localparam logic [127:0] RD2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] RD3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] RD4 = 128'hCAFEF00D_00000000_FFFFFFFF_12345678;
    localparam logic [127:0] WD1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] WD2 = 128'hBEEF_BEEF_0000_1111_2222_3333_4444_5555;

    logic         clk = 1'b0;
    logic         RESET;
    logic [1:0]   req_valid;
    logic [1:0]   req_we;
    logic [63:0]  req_addr;
    logic [255:0] req_wdata;
    logic [1:0]   req_ready;
    logic [1:0]   req_done;
    logic         req_err;
    logic [127:0] req_rdata;
    logic         ram_valid;
    logic         ram_we;
    logic [31:0]  ram_addr;
    logic [127:0] ram_wdata;
    logic         ram_ready;
    logic         ram_done;
    logic [127:0] ram_rdata;
    logic         timeout_flag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .N_REQ       (2),
        .ADDR_W      (32),
        .LINE_W      (128),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .RESET        (RESET),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .ram_valid    (ram_valid),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_ready    (ram_ready),
        .ram_done     (ram_done),
        .ram_rdata    (ram_rdata),
        .timeout_flag (timeout_flag)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        RESET     = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        ram_ready = 1'b0;
        ram_done  = 1'b0;
        ram_rdata = '0;

        // Reset held with both requesters valid
        repeat (2) step();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_req_done", req_done, 2'b00);
        check("rst_req_err", req_err, 0);
        check("rst_req_rdata", req_rdata, 0);
        check("rst_ram_valid", ram_valid, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_timeout_flag", timeout_flag, 0);
        RESET = 1'b1;
        #1;
        check("rst_release_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        step();

        // Single read from requester 0
        req_addr[31:0] = 32'h0000_1230;
        req_we         = 2'b00;
        req_valid      = 2'b01;
        #1;
        check("rd_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("rd_ram_valid", ram_valid, 1);
        check("rd_ram_we", ram_we, 0);
        check("rd_ram_addr", ram_addr, 32'h0000_1230);
        check("rd_no_done_t1", req_done, 2'b00);
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        check("rd_ram_valid_drop", ram_valid, 0);
        ram_done  = 1'b1;
        ram_rdata = RD1;
        step();
        ram_done  = 1'b0;
        ram_rdata = '0;
        check("rd_done", req_done, 2'b01);
        check("rd_rdata", req_rdata, RD1);
        check("rd_err", req_err, 0);
        check("rd_ready_in_resp", req_ready, 2'b00);
        step();
        check("rd_done_single", req_done, 2'b00);

        // Both valid continuously from a fresh reset: grants alternate 0,1,0,1
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        step();
        req_valid            = 2'b11;
        req_we               = 2'b10;
        req_addr[31:0]       = 32'h0000_2000;
        req_addr[63:32]      = 32'h0000_4560;
        req_wdata[255:128]   = WD1;
        req_wdata[127:0]     = RD4;
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            exp_id = k[0];
            #1;
            check("rr_ready", req_ready, exp_id ? 2'b10 : 2'b01);
            step();
            check("rr_ram_we", ram_we, exp_id);
            check("rr_ram_addr", ram_addr, exp_id ? 32'h0000_4560 : 32'h0000_2000);
            if (exp_id) check("rr_ram_wdata", ram_wdata, WD1);
            ram_ready = 1'b1;
            step();
            ram_ready = 1'b0;
            ram_done  = 1'b1;
            ram_rdata = RD2;
            step();
            ram_done = 1'b0;
            check("rr_done", req_done, exp_id ? 2'b10 : 2'b01);
            check("rr_ready_in_resp", req_ready, 2'b00);
            step();
        end
        req_valid = 2'b00;
        req_we    = 2'b00;
        step();

        // RAM stall: ram_ready withheld 5 cycles
        req_addr[31:0] = 32'h0000_3330;
        req_valid      = 2'b01;
        #1;
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 6; c++) begin
            check("stall_ram_valid", ram_valid, 1);
            check("stall_ram_addr", ram_addr, 32'h0000_3330);
            check("stall_ram_we", ram_we, 0);
            check("stall_no_done", req_done, 2'b00);
            if (c == 5) ram_ready = 1'b1;
            step();
        end
        ram_ready = 1'b0;
        check("stall_wait_valid", ram_valid, 0);
        ram_done  = 1'b1;
        ram_rdata = RD3;
        step();
        ram_done = 1'b0;
        check("stall_done", req_done, 2'b01);
        check("stall_rdata", req_rdata, RD3);
        step();
        check("stall_no_extra_done_1", req_done, 2'b00);
        step();
        check("stall_no_extra_done_2", req_done, 2'b00);

        // Timeout: requester 1 write, ram_ready never asserted
        req_we              = 2'b10;
        req_addr[63:32]     = 32'h0000_5550;
        req_wdata[255:128]  = WD2;
        req_valid           = 2'b10;
        #1;
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 8; c++) begin
            check("tmo_ram_valid", ram_valid, 1);
            check("tmo_no_done", req_done, 2'b00);
            step();
        end
        check("tmo_done", req_done, 2'b10);
        check("tmo_err", req_err, 1);
        check("tmo_rdata_zero", req_rdata, 0);
        check("tmo_flag", timeout_flag, 1);
        check("tmo_ram_valid_off", ram_valid, 0);
        step();
        check("tmo_done_cleared", req_done, 2'b00);
        check("tmo_flag_sticky", timeout_flag, 1);

        // ram_ready in the last counted cycle wins over the timeout
        req_we         = 2'b00;
        req_addr[31:0] = 32'h0000_6660;
        req_valid      = 2'b01;
        #1;
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 8; c++) begin
            check("edge_ram_valid", ram_valid, 1);
            if (c == 7) ram_ready = 1'b1;
            step();
        end
        ram_ready = 1'b0;
        check("edge_wait_valid", ram_valid, 0);
        ram_done  = 1'b1;
        ram_rdata = RD4;
        step();
        ram_done = 1'b0;
        check("edge_done", req_done, 2'b01);
        check("edge_err", req_err, 0);
        check("edge_rdata", req_rdata, RD4);
        check("edge_flag_sticky", timeout_flag, 1);
        step();

        // Reset asserted while waiting on RAM
        req_addr[31:0] = 32'h0000_7770;
        req_valid      = 2'b01;
        #1;
        step();
        req_valid = 2'b00;
        check("mid_ram_valid", ram_valid, 1);
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        RESET     = 1'b0;
        #1;
        check("mid_ram_valid_off", ram_valid, 0);
        check("mid_no_done", req_done, 2'b00);
        check("mid_flag_cleared", timeout_flag, 0);
        step();
        RESET     = 1'b1;
        ram_done  = 1'b1;
        ram_rdata = RD1;
        step();
        ram_done = 1'b0;
        check("mid_stale_done_ignored", req_done, 2'b00);
        check("mid_ram_valid_idle", ram_valid, 0);
        req_valid = 2'b01;
        #1;
        check("mid_idle_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
